// File: rtl/mem_dump_engine.sv
// Result-dump engine: after cpu_done, streams data memory 0..DEPTH-1 out over valid/ready.
// Optional MEM_DUMP_CHECKSUM_EN appends a modulo-2^DATA_W sum beat carrying out_last.
module mem_dump_engine #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 7,
    parameter int DEPTH          = 128,
    parameter int TIMEOUT_CYCLES = 500
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              cpu_done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              dump_done,
    output logic              timeout
);

    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam bit                WD_EN     = (TIMEOUT_CYCLES != 0);

`ifdef MEM_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_READ, S_WAIT, S_OUT, S_DONE, S_TMO, S_CSUM
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_READ, S_WAIT, S_OUT, S_DONE, S_TMO
    } state_t;
`endif

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr;
    logic [WD_W-1:0]   wdog;
    logic              wd_expire;
    logic              at_last;

`ifdef MEM_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    logic              csum_phase;
`endif

    assign wd_expire   = WD_EN && (wdog == WD_LAST);
    assign at_last     = (addr == LAST_ADDR);
    assign mem_rd_en   = (state == S_READ);
    assign mem_rd_addr = addr;
    assign busy        = (state == S_ARMED) || (state == S_READ) ||
                         (state == S_WAIT)  || (state == S_OUT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_TMO: if (start) state_next = S_ARMED;
            // cpu_done takes priority over a watchdog expiry in the same cycle
            S_ARMED: begin
                if (cpu_done)       state_next = S_READ;
                else if (wd_expire) state_next = S_TMO;
            end
            S_READ: state_next = S_WAIT;
            S_WAIT: state_next = S_OUT;
            S_OUT: begin
                if (out_ready) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                    if (csum_phase)   state_next = S_DONE;
                    else if (at_last) state_next = S_CSUM;
                    else              state_next = S_READ;
`else
                    state_next = at_last ? S_DONE : S_READ;
`endif
                end
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            S_CSUM: state_next = S_OUT;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr      <= '0;
            wdog      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            dump_done <= 1'b0;
            timeout   <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
            sum        <= '0;
            csum_phase <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE, S_TMO: begin
                    if (start) begin
                        addr      <= '0;
                        wdog      <= '0;
                        dump_done <= 1'b0;
                        timeout   <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
                        sum        <= '0;
                        csum_phase <= 1'b0;
`endif
                    end
                end
                S_ARMED: begin
                    wdog <= wdog + 1'b1;
                    if (!cpu_done && wd_expire) timeout <= 1'b1;
                end
                S_WAIT: begin
                    out_data  <= mem_rd_data;
                    out_valid <= 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
                    out_last  <= 1'b0;
                    sum       <= sum + mem_rd_data;
`else
                    out_last  <= at_last;
`endif
                end
                // Word is held until the sink takes it; address only advances on handshake
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
                        if (csum_phase)    dump_done <= 1'b1;
                        else if (!at_last) addr      <= addr + 1'b1;
`else
                        if (at_last) dump_done <= 1'b1;
                        else         addr      <= addr + 1'b1;
`endif
                    end
                end
`ifdef MEM_DUMP_CHECKSUM_EN
                S_CSUM: begin
                    out_data   <= sum;
                    out_valid  <= 1'b1;
                    out_last   <= 1'b1;
                    csum_phase <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_engine.sv
// Directed bench for mem_dump_engine: vector table for the first beats, then
// full dumps with and without backpressure, watchdog, and async reset corners.
module tb_mem_dump_engine;

    localparam int DW    = 8;
    localparam int AW    = 7;
    localparam int DEPTH = 128;
    localparam int TMO   = 30;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          cpu_done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready;
    logic          busy;
    logic          dump_done;
    logic          timeout;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem [DEPTH];

    mem_dump_engine #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .cpu_done(cpu_done),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .busy(busy), .dump_done(dump_done), .timeout(timeout)
    );

    always #5 clock = ~clock;

    // Synchronous-read memory model: data appears the cycle after the strobe
    always_ff @(posedge clock) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    typedef struct {
        bit            st;
        bit            cd;
        bit            rdy;
        bit            e_busy;
        bit            e_rden;
        logic [AW-1:0] e_addr;
        bit            e_valid;
        logic [DW-1:0] e_data;
        bit            e_last;
    } vec_t;

    vec_t vecs [11];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit s, input bit c, input bit r);
        start     = s;
        cpu_done  = c;
        out_ready = r;
        @(posedge clock);
        #1;
    endtask

    // Start, then assert cpu_done so it is sampled n edges after the arm edge
    task automatic armAndRelease(input int n);
        applyStimulus(1'b1, 1'b0, out_ready);
        for (int k = 1; k < n; k++) applyStimulus(1'b0, 1'b0, out_ready);
        applyStimulus(1'b0, 1'b1, out_ready);
        cpu_done = 1'b0;
        checkOutput("rd_en after cpu_done", 32'(mem_rd_en), 32'd1);
        checkOutput("first rd_addr", 32'(mem_rd_addr), 32'd0);
        checkOutput("no timeout on release", 32'(timeout), 32'd0);
    endtask

    // mode 0: ready always high; mode 1: ready high one cycle in four
    task automatic collectDump(input int mode);
        logic [DW-1:0] bdata [DEPTH + 4];
        bit            blast [DEPTH + 4];
        int            nb = 0;
        int            cyc = 0;
        bit            hold;
        bit            rdy;
        logic [DW-1:0] pd;
        bit            pl;
        int            badData = 0;
        int            badLast = 0;
        int            badHold = 0;
        while (cyc < 5000 && !dump_done) begin
            rdy       = (mode == 0) ? 1'b1 : (cyc % 4 == 0);
            out_ready = rdy;
            if (out_valid && rdy && nb < DEPTH + 4) begin
                bdata[nb] = out_data;
                blast[nb] = out_last;
                nb++;
            end
            hold = out_valid && !rdy;
            pd   = out_data;
            pl   = out_last;
            @(posedge clock);
            #1;
            cyc++;
            if (hold && (!out_valid || out_data !== pd || out_last !== pl)) badHold++;
        end
        checkOutput("dump_done reached", 32'(dump_done), 32'd1);
        checkOutput("beat count", 32'(nb), 32'(DEPTH));
        for (int i = 0; i < nb && i < DEPTH; i++) begin
            if (bdata[i] !== DW'(i + 1)) badData++;
            if (blast[i] !== (i == DEPTH - 1)) badLast++;
        end
        checkOutput("beat data errors", 32'(badData), 32'd0);
        checkOutput("out_last placement errors", 32'(badLast), 32'd0);
        checkOutput("held beat changed", 32'(badHold), 32'd0);
        if (mode == 0) checkOutput("cycles rd_en to done", 32'(cyc), 32'd384);
        checkOutput("busy after dump", 32'(busy), 32'd0);
        checkOutput("valid after dump", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int  k;
        bit  sawRd;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 1);
        reset     = 1'b0;
        start     = 1'b0;
        cpu_done  = 1'b0;
        out_ready = 1'b0;

        // st cd rdy | busy rden addr valid data last
        vecs[0]  = '{0, 0, 0, 0, 0, 7'd0, 0, 8'h00, 0};
        vecs[1]  = '{1, 0, 0, 1, 0, 7'd0, 0, 8'h00, 0};
        vecs[2]  = '{0, 0, 0, 1, 0, 7'd0, 0, 8'h00, 0};
        vecs[3]  = '{0, 1, 0, 1, 1, 7'd0, 0, 8'h00, 0};
        vecs[4]  = '{0, 0, 0, 1, 0, 7'd0, 0, 8'h00, 0};
        vecs[5]  = '{0, 0, 0, 1, 0, 7'd0, 1, 8'h01, 0};
        vecs[6]  = '{0, 0, 0, 1, 0, 7'd0, 1, 8'h01, 0};
        vecs[7]  = '{0, 0, 1, 1, 1, 7'd1, 0, 8'h00, 0};
        vecs[8]  = '{0, 0, 1, 1, 0, 7'd1, 0, 8'h00, 0};
        vecs[9]  = '{0, 0, 0, 1, 0, 7'd1, 1, 8'h02, 0};
        vecs[10] = '{1, 0, 0, 1, 0, 7'd1, 1, 8'h02, 0};

        #22;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset valid", 32'(out_valid), 32'd0);
        checkOutput("reset rd_en", 32'(mem_rd_en), 32'd0);
        checkOutput("reset flags", {30'd0, dump_done, timeout}, 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].st, vecs[i].cd, vecs[i].rdy);
            checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            checkOutput($sformatf("vec%0d rd_en", i), 32'(mem_rd_en), 32'(vecs[i].e_rden));
            if (vecs[i].e_rden)
                checkOutput($sformatf("vec%0d rd_addr", i), 32'(mem_rd_addr), 32'(vecs[i].e_addr));
            checkOutput($sformatf("vec%0d valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                checkOutput($sformatf("vec%0d data", i), 32'(out_data), 32'(vecs[i].e_data));
                checkOutput($sformatf("vec%0d last", i), 32'(out_last), 32'(vecs[i].e_last));
            end
        end

        // Abort the partial dump and run complete ones
        reset = 1'b0;
        #2;
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        armAndRelease(20);
        collectDump(0);
        armAndRelease(20);
        collectDump(1);

        // Watchdog expiry with cpu_done never arriving
        applyStimulus(1'b1, 1'b0, 1'b1);
        k = 0;
        sawRd = 1'b0;
        for (int c = 1; c <= TMO + 5 && k == 0; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            if (mem_rd_en) sawRd = 1'b1;
            if (timeout) k = c;
        end
        checkOutput("timeout latency", 32'(k), 32'(TMO));
        checkOutput("busy in TMO", 32'(busy), 32'd0);
        checkOutput("rd_en during timeout run", 32'(sawRd), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("restart clears timeout", 32'(timeout), 32'd0);
        checkOutput("restart busy", 32'(busy), 32'd1);

        // cpu_done coincides with the final watchdog count
        applyStimulus(1'b0, 1'b0, 1'b1);
        while (timeout) applyStimulus(1'b0, 1'b0, 1'b1);
        while (busy && !timeout) applyStimulus(1'b0, 1'b0, 1'b1);
        armAndRelease(TMO);
        collectDump(0);

        // Asynchronous reset while word 37 is on the stream
        out_ready = 1'b0;
        armAndRelease(20);
        out_ready = 1'b1;
        k = 0;
        while (k < 2000 && !(out_valid && out_data == 8'd38)) begin
            @(posedge clock);
            #1;
            k++;
        end
        checkOutput("reached word 37", 32'(out_data), 32'd38);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async rst valid", 32'(out_valid), 32'd0);
        checkOutput("async rst data", 32'(out_data), 32'd0);
        checkOutput("async rst busy", 32'(busy), 32'd0);
        checkOutput("async rst addr", 32'(mem_rd_addr), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        armAndRelease(20);
        collectDump(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_dump_engine.md
Name: mem_dump_engine

Overview:
- Synthesizable result-dump unit for the processor subsystem; replaces bench-side hierarchical memory peeking.
- Arms on a start pulse and watches the CPU's done signal with a cycle watchdog.
- On done, reads data memory addresses 0..DEPTH-1 through a synchronous read port and streams each word out on a valid/ready interface with a last marker.
- Generalised in data width, depth and timeout; adds backpressure, timeout reporting and re-arm.

Parameters:
DATA_W, 8, memory word / stream width in bits
ADDR_W, 7, memory address width
DEPTH, 128, number of words dumped; must satisfy 1 <= DEPTH <= 2^ADDR_W
TIMEOUT_CYCLES, 500, watchdog limit in cycles while armed; 0 disables the watchdog

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  single-cycle arm request
cpu_done  in  1  processor program-complete level
mem_rd_en  out  1  memory read strobe
mem_rd_addr  out  ADDR_W  memory read address
mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
out_valid  out  1  stream word valid
out_data  out  DATA_W  stream word
out_last  out  1  final word of dump, qualified by out_valid
out_ready  in  1  sink accepts word when high with out_valid
busy  out  1  high in ARMED, READ, WAIT, OUT
dump_done  out  1  sticky: full dump delivered
timeout  out  1  sticky: watchdog expired before cpu_done

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE immediately, including mid-dump.
  - All outputs go to 0; address and watchdog counters go to 0.
  - An in-flight word is discarded. No partial-dump recovery.
- States: IDLE, ARMED, READ, WAIT, OUT, DONE, TMO.
- IDLE / DONE / TMO:
  - start=1 -> ARMED next edge.
  - Clears dump_done, timeout, watchdog and addr.
  - start is ignored in all other states.
- ARMED:
  - Watchdog increments each cycle.
  - cpu_done=1 sampled -> READ.
  - Otherwise, if TIMEOUT_CYCLES!=0 and watchdog==TIMEOUT_CYCLES-1 -> TMO with timeout=1.
  - cpu_done and expiry in the same cycle: cpu_done wins (READ, no timeout).
- READ: mem_rd_en=1, mem_rd_addr=addr, for exactly one cycle -> WAIT.
- WAIT:
  - mem_rd_data is registered into out_data; out_valid=1 from next cycle -> OUT.
  - out_last=1 from next cycle iff addr==DEPTH-1.
- OUT:
  - out_valid, out_data and out_last are held stable until out_ready=1.
  - On handshake, out_valid drops next cycle.
  - If addr==DEPTH-1 -> DONE (dump_done=1); else addr+1 -> READ.
- Throughput: one word per 3 cycles with out_ready tied high.
- Latency: cpu_done sampled at edge N -> mem_rd_en high after edge N, first out_valid after edge N+2.
- Address wrap: never occurs; addr stops at DEPTH-1.
- DEPTH=1: the first word carries out_last=1.
- cpu_done deasserting after sampling has no effect on an ongoing dump.
- mem_rd_en is low outside READ; mem_rd_addr holds its last value.

Optional Feature:
- MEM_DUMP_CHECKSUM_EN defined:
  - After word DEPTH-1 is accepted, one extra beat carries the sum of all dumped words modulo 2^DATA_W (state CSUM).
  - out_last moves from the last memory word to the checksum beat.
  - The checksum beat obeys the same valid/ready hold rules.
  - dump_done is set after the checksum handshake.
  - The accumulator is cleared on start and on reset.
- Undefined: no checksum beat, no accumulator logic; behaviour exactly as above.

Test Plan:
- Memory preloaded with mem[i]=i+1; start; cpu_done at cycle 20; out_ready=1 -> 128 beats with data 0x01..0x80 in order; out_last only on 0x80; dump_done=1; 384 cycles from first mem_rd_en to the DONE transition.
- Same preload, out_ready toggled 1-cycle-high/3-low -> identical data sequence; no word dropped or duplicated; out_data stable while valid&&!ready.
- TIMEOUT_CYCLES=10, cpu_done held 0 -> timeout=1 exactly 10 cycles after entering ARMED; busy=0; mem_rd_en never asserted; a second start clears timeout.
- cpu_done rises on the same cycle the watchdog reaches 9 (TIMEOUT_CYCLES=10) -> dump proceeds; timeout stays 0.
- reset driven low while at word 37 -> all outputs 0 asynchronously; after release, start plus cpu_done -> dump restarts at address 0.
- MEM_DUMP_CHECKSUM_EN, DEPTH=4, mem={0xFF,0x02,0x10,0x01} -> 5 beats; last beat 0x12 with out_last=1; word 0x01 has out_last=0.
